// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding buffer per functional unit, round-robin grant, registered broadcast.
// Two-cycle minimum latency; src_ready drops only while a unit's buffer is full and not being drained (or on flush).
module cdb_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int TAG_W   = 4,
   parameter int DATA_W  = 32,
   parameter int SRC_W   = 2
) (
   input  logic                        clk,
   input  logic                        nRST,
   input  logic                        flush,
   input  logic [NUM_SRC-1:0]          src_valid,
   input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
   input  logic [NUM_SRC*DATA_W-1:0]   src_data,
   output logic [NUM_SRC-1:0]          src_ready,
   output logic                        cdb_valid,
   output logic [TAG_W-1:0]            cdb_tag,
   output logic [DATA_W-1:0]           cdb_data,
   output logic [SRC_W-1:0]            cdb_src,
   output logic                        cdb_conflict
);

   logic [NUM_SRC-1:0] buf_v;
   logic [TAG_W-1:0]   buf_tag  [NUM_SRC];
   logic [DATA_W-1:0]  buf_data [NUM_SRC];
   logic [SRC_W-1:0]   ptr;

   logic [NUM_SRC-1:0] grant;
   logic [SRC_W-1:0]   win;
   logic               any_grant;
   logic [SRC_W:0]     pend_cnt;
   logic               conflict;

   // Grant depends only on buffer state, so a unit's handshake never races its own arbitration.
   always_comb begin
      int idx;
      idx       = 0;
      grant     = '0;
      win       = '0;
      any_grant = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         if (!any_grant && buf_v[idx]) begin
            any_grant  = 1'b1;
            grant[idx] = 1'b1;
            win        = SRC_W'(idx);
         end
      end
   end

   always_comb begin
      pend_cnt = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         pend_cnt = pend_cnt + (SRC_W+1)'(buf_v[i]);
      end
      conflict = (pend_cnt >= (SRC_W+1)'(2));
   end

   assign src_ready = {NUM_SRC{!flush}} & (~buf_v | grant);

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         buf_v        <= '0;
         ptr          <= '0;
         cdb_valid    <= 1'b0;
         cdb_tag      <= '0;
         cdb_data     <= '0;
         cdb_src      <= '0;
         cdb_conflict <= 1'b0;
         for (int i = 0; i < NUM_SRC; i++) begin
            buf_tag[i]  <= '0;
            buf_data[i] <= '0;
         end
      end else if (flush) begin
         buf_v        <= '0;
         ptr          <= '0;
         cdb_valid    <= 1'b0;
         cdb_conflict <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (src_valid[i] && src_ready[i]) begin
               buf_v[i]    <= 1'b1;
               buf_tag[i]  <= src_tag[i*TAG_W +: TAG_W];
               buf_data[i] <= src_data[i*DATA_W +: DATA_W];
            end else if (grant[i]) begin
               buf_v[i] <= 1'b0;
            end
         end
         cdb_valid    <= any_grant;
         cdb_conflict <= conflict;
         if (any_grant) begin
            cdb_tag  <= buf_tag[win];
            cdb_data <= buf_data[win];
            cdb_src  <= win;
            ptr      <= (win == SRC_W'(NUM_SRC-1)) ? '0 : win + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: table-driven ready checks plus a broadcast scoreboard and hand-written flush/reset sequences.
module tb_cdb_arbiter;

   logic         clk;
   logic         nRST;
   logic         flush;
   logic [3:0]   src_valid;
   logic [15:0]  src_tag;
   logic [127:0] src_data;
   logic [3:0]   src_ready;
   logic         cdb_valid;
   logic [3:0]   cdb_tag;
   logic [31:0]  cdb_data;
   logic [1:0]   cdb_src;
   logic         cdb_conflict;

   cdb_arbiter #(.NUM_SRC(4), .TAG_W(4), .DATA_W(32), .SRC_W(2)) dut (
      .clk(clk), .nRST(nRST), .flush(flush),
      .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data), .src_ready(src_ready),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src),
      .cdb_conflict(cdb_conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  tag;
      logic [31:0] data;
      logic [1:0]  src;
      logic        conf;
   } bc_t;

   typedef struct {
      logic        fl;
      logic [3:0]  vld;
      logic [15:0] tags;
      logic [3:0]  rdy;
      logic        push;
      logic [3:0]  btag;
      logic [1:0]  bsrc;
      logic        bconf;
   } vec_t;

   bc_t  exp_q[$];
   bc_t  mon_e;
   vec_t tbl[16];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic logic [31:0] mkdata(input int s, input logic [3:0] t);
      return 32'hC0DE_0000 | (32'(s) << 8) | 32'(t);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic push_bc(input logic [3:0] t, input logic [1:0] s, input logic c);
      bc_t e;
      e.tag  = t;
      e.data = mkdata(int'(s), t);
      e.src  = s;
      e.conf = c;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic fl, input logic [3:0] v, input logic [15:0] tg);
      flush     = fl;
      src_valid = v;
      for (int i = 0; i < 4; i++) begin
         src_tag[i*4 +: 4]   = tg[i*4 +: 4];
         src_data[i*32 +: 32] = mkdata(i, tg[i*4 +: 4]);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         drive(1'b0, 4'b0000, 16'h0000);
      end
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      drive(1'b0, 4'b0000, 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
      chk("rst_cdb_tag", 32'(cdb_tag), 32'd0);
      chk("rst_cdb_data", cdb_data, 32'd0);
      chk("rst_cdb_src", 32'(cdb_src), 32'd0);
      chk("rst_cdb_conflict", 32'(cdb_conflict), 32'd0);
      nRST = 1'b1;
      #1;
      chk("rst_src_ready", 32'(src_ready), 32'hF);
   endtask

   // Every broadcast must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (cdb_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL cdb_unexpected: got tag %0h src %0d, expected no broadcast", cdb_tag, cdb_src);
         end else begin
            mon_e = exp_q.pop_front();
            chk("bc_tag", 32'(cdb_tag), 32'(mon_e.tag));
            chk("bc_data", cdb_data, mon_e.data);
            chk("bc_src", 32'(cdb_src), 32'(mon_e.src));
            chk("bc_conflict", 32'(cdb_conflict), 32'(mon_e.conf));
         end
      end
   end

   initial begin
      int s0n, s1n;
      logic [3:0] r;

      // Contention from ptr=0, then source 3 streaming tags 0..7.
      tbl[0] = '{1'b0, 4'b1011, 16'h3021, 4'b1111, 1'b1, 4'h1, 2'd0, 1'b1};
      tbl[1] = '{1'b0, 4'b0000, 16'h0000, 4'b0101, 1'b1, 4'h2, 2'd1, 1'b1};
      tbl[2] = '{1'b0, 4'b0000, 16'h0000, 4'b0111, 1'b1, 4'h3, 2'd3, 1'b0};
      tbl[3] = '{1'b0, 4'b0000, 16'h0000, 4'b1111, 1'b0, 4'h0, 2'd0, 1'b0};
      tbl[4] = '{1'b0, 4'b0000, 16'h0000, 4'b1111, 1'b0, 4'h0, 2'd0, 1'b0};
      for (int t = 0; t < 8; t++)
         tbl[5+t] = '{1'b0, 4'b1000, {4'(t), 12'h000}, 4'b1111, 1'b1, 4'(t), 2'd3, 1'b0};
      for (int j = 13; j < 16; j++)
         tbl[j] = '{1'b0, 4'b0000, 16'h0000, 4'b1111, 1'b0, 4'h0, 2'd0, 1'b0};

      nRST = 1'b0;
      drive(1'b0, 4'b0000, 16'h0000);

      // Single result from source 2.
      do_reset();
      @(posedge clk); #1;
      drive(1'b0, 4'b0100, 16'h0500);
      src_data[64 +: 32] = 32'hDEADBEEF;
      begin
         bc_t e;
         e.tag = 4'h5; e.data = 32'hDEADBEEF; e.src = 2'd2; e.conf = 1'b0;
         exp_q.push_back(e);
      end
      @(negedge clk);
      chk("single_rdy", 32'(src_ready), 32'hF);
      idle(3);
      @(negedge clk);
      chk("single_one_cycle", 32'(cdb_valid), 32'd0);
      chk("single_q_empty", 32'(exp_q.size()), 32'd0);

      // Table rows.
      do_reset();
      for (int j = 0; j < 16; j++) begin
         @(posedge clk); #1;
         drive(tbl[j].fl, tbl[j].vld, tbl[j].tags);
         if (tbl[j].push) push_bc(tbl[j].btag, tbl[j].bsrc, tbl[j].bconf);
         @(negedge clk);
         chk($sformatf("row%0d_rdy", j), 32'(src_ready), 32'(tbl[j].rdy));
      end
      chk("table_q_empty", 32'(exp_q.size()), 32'd0);

      // Fairness: sources 0 and 1 stream continuously for 20 cycles.
      do_reset();
      for (int k = 0; k < 21; k++) push_bc(4'(k/2), 2'(k%2), (k < 20));
      s0n = 0; s1n = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         drive(1'b0, 4'b0011, {8'h00, 4'(s1n), 4'(s0n)});
         @(negedge clk);
         r = src_ready;
         chk($sformatf("fair_rdy_c%0d", c), 32'(r), (c == 0) ? 32'hF : ((c % 2) ? 32'hD : 32'hE));
         if (r[0]) s0n++;
         if (r[1]) s1n++;
      end
      idle(4);
      @(negedge clk);
      chk("fair_q_empty", 32'(exp_q.size()), 32'd0);

      // Flush with three pending and a concurrent new request; ptr set to 2 beforehand.
      do_reset();
      @(posedge clk); #1;
      drive(1'b0, 4'b0010, 16'h0090);
      push_bc(4'h9, 2'd1, 1'b0);
      idle(3);
      @(posedge clk); #1;
      drive(1'b0, 4'b0111, 16'h0321);
      @(posedge clk); #1;
      drive(1'b1, 4'b0001, 16'h0004);
      @(negedge clk);
      chk("flush_rdy", 32'(src_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         drive(1'b0, 4'b0000, 16'h0000);
         @(negedge clk);
         chk($sformatf("flush_no_bc%0d", i), 32'(cdb_valid), 32'd0);
         if (i == 0) chk("flush_rdy_after", 32'(src_ready), 32'hF);
      end
      @(posedge clk); #1;
      drive(1'b0, 4'b1011, 16'h7065);
      push_bc(4'h5, 2'd0, 1'b1);
      push_bc(4'h6, 2'd1, 1'b1);
      push_bc(4'h7, 2'd3, 1'b0);
      idle(5);
      @(negedge clk);
      chk("flush_q_empty", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset while broadcasting.
      do_reset();
      @(posedge clk); #1;
      drive(1'b0, 4'b1011, 16'hC0BA);
      push_bc(4'hA, 2'd0, 1'b1);
      idle(2);
      @(negedge clk);
      chk("areset_pre_valid", 32'(cdb_valid), 32'd1);
      #2;
      nRST = 1'b0;
      #1;
      chk("areset_valid", 32'(cdb_valid), 32'd0);
      chk("areset_tag", 32'(cdb_tag), 32'd0);
      chk("areset_data", cdb_data, 32'd0);
      chk("areset_src", 32'(cdb_src), 32'd0);
      chk("areset_conflict", 32'(cdb_conflict), 32'd0);
      @(posedge clk);
      @(negedge clk);
      nRST = 1'b1;
      #1;
      chk("areset_rdy", 32'(src_ready), 32'hF);
      idle(2);
      @(posedge clk); #1;
      drive(1'b0, 4'b1001, 16'hE00D);
      push_bc(4'hD, 2'd0, 1'b1);
      push_bc(4'hE, 2'd3, 1'b0);
      idle(4);
      @(negedge clk);
      chk("areset_q_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbiter for the Tomasulo common data bus (CDB).
- Up to NUM_SRC functional units (ALU, mul/div, load unit, ...) each hand one completed result (ROB/RS tag + value) into a per-source one-entry holding buffer.
- Each cycle the arbiter grants one buffered result round-robin and drives it onto a registered CDB broadcast, which reservation stations and the register file snoop.
- Sits between the execution units and the CDB consumers in the top-level CPU.

Parameters:
- NUM_SRC, 4, number of requesting functional units (2..8).
- TAG_W, 4, reservation-station/ROB tag width.
- DATA_W, 32, result data width.
- SRC_W, 2, width of source index; must equal ceil(log2(NUM_SRC)).

Ports:
- clk  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- flush  input  1  synchronous squash (branch mispredict); drops all pending results.
- src_valid  input  NUM_SRC  per-source result-valid.
- src_tag  input  NUM_SRC*TAG_W  per-source tag; source i occupies bits [i*TAG_W +: TAG_W].
- src_data  input  NUM_SRC*DATA_W  per-source result; source i occupies bits [i*DATA_W +: DATA_W].
- src_ready  output  NUM_SRC  per-source accept; a transfer occurs when src_valid[i] && src_ready[i] at a rising edge.
- cdb_valid  output  1  broadcast valid.
- cdb_tag  output  TAG_W  broadcast tag.
- cdb_data  output  DATA_W  broadcast value.
- cdb_src  output  SRC_W  index of the unit that won the broadcast.
- cdb_conflict  output  1  registered; 1 when the cycle's arbitration saw 2 or more buffers pending.

Behaviour:

Reset (nRST=0, asynchronous):
- All buffers invalid; round-robin pointer = 0.
- cdb_valid, cdb_tag, cdb_data, cdb_src, cdb_conflict = 0.
- src_ready = all ones as soon as reset releases (buffers empty).

Reset mid-operation:
- Any pending or broadcasting result is lost.
- No partial broadcast after release.

Holding buffers:
- One entry per source: buf_v[i], buf_tag[i], buf_data[i].
- src_ready[i] = !flush && (!buf_v[i] || grant[i]), combinational. A buffer being drained this cycle can be refilled in the same edge, giving 1 result/cycle per source under no contention.
- On a transfer, the buffer loads tag and data and buf_v[i] is set.
- On grant without refill, buf_v[i] is cleared.

Arbitration (combinational from buffer state only, never from src_* directly):
- Scan buf_v starting at index ptr, ascending with wrap-around from NUM_SRC-1 to 0.
- The first valid index wins, giving a one-hot grant.
- If no buffer is valid, there is no grant and ptr holds.
- After a grant to index w, ptr <= (w+1) mod NUM_SRC, so the winner becomes lowest priority next cycle.

CDB register, at each rising edge:
- cdb_valid <= any grant && !flush.
- When granting: cdb_tag, cdb_data <= winner's buffer contents; cdb_src <= w.
- When not granting: cdb_tag, cdb_data, cdb_src hold their previous values (don't-care while cdb_valid=0).
- cdb_conflict <= (popcount(buf_v) >= 2) && !flush.

Latency and fairness:
- src_valid sampled at edge k → earliest cdb_valid visible after edge k+1, i.e. 2-cycle minimum latency.
- A buffered result is broadcast within NUM_SRC cycles.
- Exactly one broadcast per cycle maximum; no tag is broadcast twice.

Flush:
- When flush=1 at an edge, all buf_v clear, cdb_valid <= 0, ptr <= 0, and no transfer is accepted (src_ready=0 that cycle).
- Flush overrides simultaneous accept and grant.

Simultaneous events:
- Accept into buffer i and grant of buffer i in the same edge: the old entry is broadcast and the new entry is held.
- Accepts on several sources in the same edge are all accepted when their ready is high.

Test Plan:
- Reset then single result: src_valid[2]=1, tag=4'h5, data=32'hDEADBEEF for 1 cycle → src_ready[2]=1; two edges later cdb_valid=1, cdb_tag=5, cdb_data=DEADBEEF, cdb_src=2 for exactly one cycle.
- Contention: sources 0,1,3 present tags 1,2,3 in the same cycle with ptr=0 → broadcasts in order src 0,1,3 on three consecutive cycles; cdb_conflict=1 in the cycles when ≥2 remained pending, then 0.
- Fairness/back-pressure: sources 0 and 1 hold src_valid=1 continuously with incrementing tags → CDB alternates 0,1,0,1; src_ready[i] low in cycles where buf i is full and not granted; no tag lost or duplicated over 20 cycles.
- Back-to-back single source: only source 3 streams tags 0..7 every cycle → src_ready[3] stays 1, and the CDB shows tags 0..7 on 8 consecutive cycles after the 2-cycle latency.
- Flush: 3 buffers pending, assert flush for 1 cycle concurrently with a new src_valid[0] → no further cdb_valid from old or new entries, ptr=0, src_ready=0 during the flush cycle, normal operation on the next request.
- Async reset mid-burst: drop nRST between clock edges while cdb_valid=1 → all CDB outputs 0 immediately; after release the first request broadcasts from src 0 priority.
